// File: rtl/cmm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : cmm_pkg                                                          |
// | Purpose : Shared definitions for the count-match monitor: event flag bit   |
// |           positions, monitor FSM states and the event record layout.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package cmm_pkg;

  // Nominal counter width; the event record below is laid out for this width.
  localparam int CMM_W = 4;

  // Bit positions inside the 3-bit flag field {LOAD, WRAP, MATCH}.
  localparam int FLG_MATCH = 0;
  localparam int FLG_WRAP  = 1;
  localparam int FLG_LOAD  = 2;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_PRIMING  = 2'd1,
    ST_RUN      = 2'd2
  } cmm_state_t;

  typedef struct packed {
    logic [2:0]       flags;
    logic [CMM_W-1:0] value;
  } cmm_evt_t;

endpackage
`default_nettype wire

// File: rtl/count_match_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: count_match_monitor_if                                          |
// | Purpose  : valid/ready event stream from the monitor to its consumer.      |
// |   evt_valid  head event present          (master -> slave)                 |
// |   evt_ready  consumer takes head         (slave  -> master)                |
// |   evt_flags  {LOAD,WRAP,MATCH} of head    (master -> slave)                |
// |   evt_value  count value of head event    (master -> slave)                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface count_match_monitor_if #(
  parameter int W = 4
);
  logic         evt_valid;
  logic         evt_ready;
  logic [2:0]   evt_flags;
  logic [W-1:0] evt_value;

  modport master (output evt_valid, output evt_flags, output evt_value, input evt_ready);
  modport slave  (input evt_valid, input evt_flags, input evt_value, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/cmm_evt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : cmm_evt_fifo                                                     |
// | Purpose : Synchronous FIFO holding monitor events. The head is presented   |
// |           directly from storage; it reads as zero while the FIFO is empty. |
// |   clk, rst  clock, synchronous active-high reset (empties the FIFO)        |
// |   push/din  write request and data; ignored when full unless popping too   |
// |   pop       read request; ignored when empty                               |
// |   dout      head entry                                                     |
// |   full      DEPTH entries held;  empty  no entries held                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module cmm_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/count_match_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : count_match_monitor                                              |
// | Purpose : Watches a loadable up-counter and queues MATCH / WRAP / LOAD     |
// |           events for a valid/ready consumer.                               |
// |   clk, rst   clock, synchronous active-high reset                          |
// |   en         monitor enable (arms DISARMED -> PRIMING -> RUN)              |
// |   cnt_in     counter output                                                |
// |   cnt_jump   counter load or reset, same cycle the counter sees it         |
// |   cmp_val    compare value                                                 |
// |   evt        event stream (count_match_monitor_if.master)                  |
// |   fifo_full  event FIFO holds DEPTH entries                                |
// |   drop_cnt   saturating dropped-event count                                |
// | Build option: CMM_DROP_CNT_EN adds the drop_cnt port and counter; without  |
// |   it, events arriving at a full FIFO are dropped silently.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module count_match_monitor
  import cmm_pkg::*;
#(
  parameter int W      = 4,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [W-1:0]         cnt_in,
  input  logic                 cnt_jump,
  input  logic [W-1:0]         cmp_val,
  count_match_monitor_if.master evt,
  output logic                 fifo_full
`ifdef CMM_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0]    drop_cnt
`endif
);

  cmm_state_t   state;
  cmm_state_t   state_nxt;
  logic [W-1:0] prev;
  logic         jump_q;
  logic [2:0]   flags;
  logic         run_eval;
  logic         capture;
  logic         push_req;
  logic         pop;
  logic         drop;
  logic         fifo_empty;
  logic [W+2:0] fifo_dout;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= ST_DISARMED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = ST_DISARMED;
    end else begin
      case (state)
        ST_DISARMED: state_nxt = ST_PRIMING;
        ST_PRIMING:  state_nxt = ST_RUN;
        ST_RUN:      state_nxt = ST_RUN;
        default:     state_nxt = ST_DISARMED;
      endcase
    end
  end

  // Evaluation only happens on an edge where the monitor is still enabled;
  // an edge that sees en low is the one that disarms it.
  assign run_eval = (state == ST_RUN) && en;
  assign capture  = (state == ST_PRIMING) && en;

  // ---------------------------------------------------------------- classify
  always_comb begin
    flags            = '0;
    flags[FLG_LOAD]  = jump_q;
    flags[FLG_WRAP]  = !jump_q && (prev == {W{1'b1}}) && (cnt_in == '0);
    // A held count that equals cmp_val reports once; a load landing on the
    // same value as before still counts as a fresh arrival.
    flags[FLG_MATCH] = (cnt_in == cmp_val) && ((cnt_in != prev) || jump_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= '0;
      jump_q <= 1'b0;
    end else if (run_eval || capture) begin
      prev   <= cnt_in;
      jump_q <= cnt_jump;
    end
  end

  // ---------------------------------------------------------------- queue
  assign push_req = run_eval && (flags != '0);
  assign pop      = evt.evt_valid && evt.evt_ready;
  assign drop     = push_req && fifo_full && !pop;

  cmm_evt_fifo #(
    .DEPTH (DEPTH),
    .DW    (W + 3)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   ({flags, cnt_in}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_flags = fifo_dout[W+2:W];
  assign evt.evt_value = fifo_dout[W-1:0];

`ifdef CMM_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                          drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_match_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_count_match_monitor                                           |
// | Purpose : Directed self-checking bench for count_match_monitor. A model of |
// |           the 4-bit loadable counter drives cnt_in; popped events are      |
// |           collected and compared with hand-computed sequences.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_count_match_monitor;
  import cmm_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] cnt_in;
  logic         cnt_jump;
  logic [W-1:0] cmp_val;
  logic         fifo_full;
  logic [W-1:0] ldv;
  logic         cnt_run;
`ifdef CMM_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  cmm_evt_t q[$];

  count_match_monitor_if #(.W(W)) ev ();

  count_match_monitor #(.W(W), .DEPTH(4), .DROP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cnt_in    (cnt_in),
    .cnt_jump  (cnt_jump),
    .cmp_val   (cmp_val),
    .evt       (ev.master),
    .fifo_full (fifo_full)
`ifdef CMM_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Record every event the consumer accepts; the pop happens on the next edge.
  always @(negedge clk) begin
    if (ev.evt_valid && ev.evt_ready) q.push_back({ev.evt_flags, ev.evt_value});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmm_evt_t qget(input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  // One clock; afterwards the counter model advances like the real counter.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cnt_jump)     cnt_in = ldv;
    else if (cnt_run) cnt_in = cnt_in + 4'd1;
    cnt_jump = 1'b0;
  endtask

  task automatic run_until(input logic [W-1:0] v);
    int n = 0;
    while (cnt_in != v && n < 40) begin
      cyc();
      n++;
    end
    tests++;
    assert (n < 40) else begin
      fails++;
      $error("FAIL run_until: observed timeout expected count %0d", v);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cnt_jump = 1'b0; ldv = '0; cnt_in = '0;
    cnt_run = 1'b0; cmp_val = 4'd5; ev.evt_ready = 1'b1;
    cyc(); cyc();
    check("rst_valid", ev.evt_valid, 0);
    check("rst_flags", ev.evt_flags, 0);
    check("rst_value", ev.evt_value, 0);
    check("rst_full", fifo_full, 0);
`ifdef CMM_DROP_CNT_EN
    check("rst_drop", drop_cnt, 0);
`endif

    // 1: free run with cmp_val=5
    rst = 1'b0; en = 1'b1; cnt_run = 1'b1; q.delete();
    run_until(4'd5);
    cyc();
    check("t1_m_valid", ev.evt_valid, 1);
    check("t1_m_flags", ev.evt_flags, 3'b001);
    check("t1_m_value", ev.evt_value, 5);
    run_until(4'd15);
    cyc(); cyc();
    check("t1_w_valid", ev.evt_valid, 1);
    check("t1_w_flags", ev.evt_flags, 3'b010);
    check("t1_w_value", ev.evt_value, 0);
    cyc();
    check("t1_drained", ev.evt_valid, 0);
    check("t1_qsize", q.size(), 2);
    check("t1_q0", qget(0), {3'b001, 4'd5});
    check("t1_q1", qget(1), {3'b010, 4'd0});

    // 2: cmp_val=0 across rollover
    q.delete(); cmp_val = 4'd0;
    run_until(4'd15);
    cyc(); cyc();
    check("t2_flags", ev.evt_flags, 3'b011);
    check("t2_value", ev.evt_value, 0);
    cyc();
    check("t2_qsize", q.size(), 1);
    check("t2_q0", qget(0), {3'b011, 4'd0});

    // 3: load 9 at count 7, then load 0 from 15
    q.delete(); cmp_val = 4'd9;
    run_until(4'd7);
    cnt_jump = 1'b1; ldv = 4'd9;
    cyc(); cyc();
    check("t3_lm_flags", ev.evt_flags, 3'b101);
    check("t3_lm_value", ev.evt_value, 9);
    run_until(4'd15);
    cnt_jump = 1'b1; ldv = 4'd0;
    cyc(); cyc();
    check("t3_l_valid", ev.evt_valid, 1);
    check("t3_l_flags", ev.evt_flags, 3'b100);
    check("t3_l_value", ev.evt_value, 0);
    cyc();
    check("t3_qsize", q.size(), 2);
    check("t3_q0", qget(0), {3'b101, 4'd9});
    check("t3_q1", qget(1), {3'b100, 4'd0});

    // 4: six LOAD events into a blocked 4-entry FIFO
    q.delete(); cmp_val = 4'd15; ev.evt_ready = 1'b0; cnt_run = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cnt_jump = 1'b1; ldv = 4'(k);
      cyc();
    end
    cyc();
    check("t4_full", fifo_full, 1);
    check("t4_valid", ev.evt_valid, 1);
    check("t4_head_flags", ev.evt_flags, 3'b100);
    check("t4_head_value", ev.evt_value, 1);
    cyc();
    check("t4_head_hold", ev.evt_value, 1);
`ifdef CMM_DROP_CNT_EN
    check("t4_drop", drop_cnt, 2);
`endif
    ev.evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    check("t4_qsize", q.size(), 4);
    for (int k = 0; k < 4; k++) check("t4_order", qget(k), {3'b100, 4'(k + 1)});
    check("t4_empty", ev.evt_valid, 0);
    check("t4_notfull", fifo_full, 0);

    // 5: reset in the middle of a drain, then re-arm
    ev.evt_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cnt_jump = 1'b1; ldv = 4'(k + 8);
      cyc();
    end
    cyc();
    check("t5_head", ev.evt_value, 9);
    ev.evt_ready = 1'b1;
    cyc();
    check("t5_mid_valid", ev.evt_valid, 1);
    check("t5_mid_value", ev.evt_value, 10);
    rst = 1'b1;
    cyc();
    check("t5_rst_valid", ev.evt_valid, 0);
    check("t5_rst_flags", ev.evt_flags, 0);
    check("t5_rst_value", ev.evt_value, 0);
    check("t5_rst_full", fifo_full, 0);
`ifdef CMM_DROP_CNT_EN
    check("t5_rst_drop", drop_cnt, 0);
`endif
    q.delete(); cmp_val = 4'd12; cnt_run = 1'b1; rst = 1'b0;
    cyc(); cyc(); cyc();
    check("t5_prime_quiet", ev.evt_valid, 0);
    cmp_val = 4'd14;
    cyc();
    check("t5_run_valid", ev.evt_valid, 1);
    check("t5_run_flags", ev.evt_flags, 3'b001);
    check("t5_run_value", ev.evt_value, 14);

    // 6: disable across a wrap, then full + push + pop in one cycle
    en = 1'b0;
    cyc();
    q.delete();
    cyc(); cyc();
    cmp_val = 4'd9; en = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("t6_nowrap_valid", ev.evt_valid, 0);
    check("t6_nowrap_q", q.size(), 0);

    cnt_run = 1'b0; ev.evt_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cnt_jump = 1'b1; ldv = 4'(k);
      cyc();
    end
    check("t6_full", fifo_full, 1);
    ev.evt_ready = 1'b1;
    cyc();
    ev.evt_ready = 1'b0;
    check("t6_pp_full", fifo_full, 1);
    check("t6_pp_head", ev.evt_value, 2);
`ifdef CMM_DROP_CNT_EN
    check("t6_pp_drop", drop_cnt, 0);
`endif
    ev.evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    check("t6_qsize", q.size(), 5);
    for (int k = 0; k < 5; k++) check("t6_order", qget(k), {3'b100, 4'(k + 1)});
    check("t6_empty", ev.evt_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
